// File: rtl/uart_pkg.sv
// Shared UART definitions: receive-side state encoding and the parity type,
// used by both the receive and transmit sides.
package uart_pkg;

   // Receiver FSM states
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_e;

   // Parity type: 1'b0 = even (parity bit makes the total count of ones even)
   localparam logic PARITY_TYPE = 1'b0;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line. Both flops reset
// high so that the line reads idle out of reset.
module uart_rx_sync (
   input  logic clk,
   input  logic rstn,
   input  logic d,
   output logic q
);

   logic meta;

   // Two-stage resynchronisation into the clk domain
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_with_parity.sv
// UART receiver that assembles NUM_WORDS words into one output frame with a
// valid/ready handshake, frame/parity error flags and an overflow pulse.
// Optional feature: define UART_RX_PARITY_EN for an even-parity bit per word;
// without it the PARITY state is unreachable and m_parity_err is tied low.
module uart_rx_with_parity #(
   parameter int CLOCKS_PER_PULSE = 4,
   parameter int BITS_PER_WORD    = 8,
   parameter int W_OUT            = 24,
   localparam int NUM_WORDS       = W_OUT / BITS_PER_WORD
) (
   input  logic                               clk,
   input  logic                               rstn,
   input  logic                               rx,
   output logic [NUM_WORDS*BITS_PER_WORD-1:0] m_data,
   output logic                               m_valid,
   input  logic                               m_ready,
   output logic                               m_parity_err,
   output logic                               m_frame_err,
   output logic                               overflow
);

   import uart_pkg::*;

   localparam int W_FRAME = NUM_WORDS * BITS_PER_WORD;
   localparam int W_CLK   = $clog2(CLOCKS_PER_PULSE);
   localparam int W_BIT   = $clog2(BITS_PER_WORD + 1);
   localparam int W_WRD   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   // The synchronizer plus edge detect already eat two clocks of the start bit
   localparam int START_WAIT = CLOCKS_PER_PULSE / 2 - 2;

   rx_state_e          state;
   logic [W_CLK-1:0]   c_clk;
   logic [W_BIT-1:0]   c_bits;
   logic [W_WRD-1:0]   c_words;
   logic [BITS_PER_WORD-1:0] shreg;
   logic [W_FRAME-1:0] accum;
   logic               frm_acc;
   logic               done;
   logic               rx_s;
   logic               rx_prev;
   logic               tick;
   logic               start_tick;
   logic               out_free;

   uart_rx_sync u_sync (
      .clk  (clk),
      .rstn (rstn),
      .d    (rx),
      .q    (rx_s)
   );

   assign tick       = (c_clk == W_CLK'(CLOCKS_PER_PULSE - 1));
   assign start_tick = (c_clk == W_CLK'(START_WAIT));
   assign out_free   = !m_valid || m_ready;

`ifdef UART_RX_PARITY_EN
   logic par_acc;
   logic par_err_q;
   assign m_parity_err = par_err_q;
`else
   assign m_parity_err = 1'b0;
`endif

   // Receive FSM, frame assembly and output register with handshake
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         c_clk       <= '0;
         c_bits      <= '0;
         c_words     <= '0;
         shreg       <= '0;
         accum       <= '0;
         frm_acc     <= 1'b0;
         done        <= 1'b0;
         rx_prev     <= 1'b1;
         m_data      <= '0;
         m_valid     <= 1'b0;
         m_frame_err <= 1'b0;
         overflow    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_acc     <= 1'b0;
         par_err_q   <= 1'b0;
`endif
      end else begin
         rx_prev  <= rx_s;
         overflow <= 1'b0;
         done     <= 1'b0;

         if (m_valid && m_ready) m_valid <= 1'b0;

         // A completed frame loads if the output is free (or handshaking now),
         // otherwise it is dropped; either way the accumulators start afresh.
         if (done) begin
            if (out_free) begin
               m_data      <= accum;
               m_valid     <= 1'b1;
               m_frame_err <= frm_acc;
`ifdef UART_RX_PARITY_EN
               par_err_q   <= par_acc;
`endif
            end else begin
               overflow <= 1'b1;
            end
            frm_acc <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_acc <= 1'b0;
`endif
         end

         case (state)
            IDLE: begin
               if (rx_prev && !rx_s) begin
                  state <= START;
                  c_clk <= '0;
               end
            end
            START: begin
               if (start_tick) begin
                  c_clk  <= '0;
                  c_bits <= '0;
                  state  <= rx_s ? IDLE : DATA;
               end else begin
                  c_clk <= c_clk + 1'b1;
               end
            end
            DATA: begin
               if (tick) begin
                  c_clk  <= '0;
                  shreg  <= {rx_s, shreg[BITS_PER_WORD-1:1]};
                  c_bits <= c_bits + 1'b1;
                  if (c_bits == W_BIT'(BITS_PER_WORD - 1)) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end else begin
                  c_clk <= c_clk + 1'b1;
               end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
               if (tick) begin
                  c_clk <= '0;
                  if (rx_s != (^shreg ^ PARITY_TYPE)) par_acc <= 1'b1;
                  state <= STOP;
               end else begin
                  c_clk <= c_clk + 1'b1;
               end
`else
               state <= IDLE;
`endif
            end
            STOP: begin
               if (tick) begin
                  c_clk <= '0;
                  if (!rx_s) frm_acc <= 1'b1;
                  for (int w = 0; w < NUM_WORDS; w++) begin
                     if (c_words == W_WRD'(w)) accum[w*BITS_PER_WORD +: BITS_PER_WORD] <= shreg;
                  end
                  if (c_words == W_WRD'(NUM_WORDS - 1)) begin
                     c_words <= '0;
                     done    <= 1'b1;
                  end else begin
                     c_words <= c_words + 1'b1;
                  end
                  state <= IDLE;
               end else begin
                  c_clk <= c_clk + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_with_parity.sv
// Self-checking bench for uart_rx_with_parity: table-driven frames, hand-written
// glitch/overflow/reset sequences and randomized frames against a word-level model.
module tb_uart_rx_with_parity;

   localparam int CPP = 4;
   localparam int BPW = 8;
   localparam int WO  = 24;
   localparam int NW  = WO / BPW;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          rx = 1'b1;
   logic          m_ready = 1'b1;
   logic [WO-1:0] m_data;
   logic          m_valid;
   logic          m_parity_err;
   logic          m_frame_err;
   logic          overflow;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [WO-1:0] data;
      logic          pe;
      logic          fe;
   } result_t;

   typedef struct {
      logic [WO-1:0] frame;
      logic [NW-1:0] bad_par;
      logic [NW-1:0] bad_stop;
      logic [WO-1:0] exp_d;
      logic          exp_pe;
      logic          exp_fe;
   } vec_t;

   result_t got_q[$];
   int      rd_idx = 0;
   int      ovf_cnt = 0;
   int      valid_cyc = 0;

   always #5 clk = ~clk;

   uart_rx_with_parity #(
      .CLOCKS_PER_PULSE (CPP),
      .BITS_PER_WORD    (BPW),
      .W_OUT            (WO)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .rx           (rx),
      .m_data       (m_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_parity_err (m_parity_err),
      .m_frame_err  (m_frame_err),
      .overflow     (overflow)
   );

   // Record every accepted frame, overflow pulse and valid cycle
   always @(negedge clk) begin
      if (rstn) begin
         if (m_valid && m_ready) got_q.push_back('{m_data, m_parity_err, m_frame_err});
         if (overflow) ovf_cnt++;
         if (m_valid) valid_cyc++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      repeat (CPP) @(posedge clk);
      #1;
   endtask

   // Start, data LSB first, optional parity, stop, then one idle bit
   task automatic send_word(input logic [BPW-1:0] d, input logic bad_par, input logic bad_stop);
      send_bit(1'b0);
      for (int i = 0; i < BPW; i++) send_bit(d[i]);
      if (PAR_EN) send_bit(^d ^ bad_par);
      send_bit(!bad_stop);
      send_bit(1'b1);
   endtask

   task automatic send_frame(input logic [WO-1:0] f, input logic [NW-1:0] bp,
                             input logic [NW-1:0] bs);
      for (int w = 0; w < NW; w++) send_word(f[w*BPW +: BPW], bp[w], bs[w]);
   endtask

   // Expect exactly one new accepted frame, bounded wait
   task automatic expect_frame(input string name, input logic [WO-1:0] d, input logic pe,
                               input logic fe);
      int n = 0;
      while (got_q.size() <= rd_idx && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({name, "_count"}, got_q.size() - rd_idx, 1);
      if (got_q.size() > rd_idx) begin
         chk({name, "_data"}, got_q[rd_idx].data, d);
         chk({name, "_perr"}, got_q[rd_idx].pe, pe);
         chk({name, "_ferr"}, got_q[rd_idx].fe, fe);
      end
      rd_idx = got_q.size();
   endtask

   initial begin
      vec_t          vecs[4];
      int            ovf_base;
      int            vc_base;
      logic [WO-1:0] rf;
      logic [NW-1:0] rbp;
      logic [NW-1:0] rbs;

      vecs[0] = '{24'h0F3CA5, 3'b000, 3'b000, 24'h0F3CA5, 1'b0, 1'b0};
      vecs[1] = '{24'h0F3CA5, 3'b010, 3'b000, 24'h0F3CA5, PAR_EN, 1'b0};
      vecs[2] = '{24'hCCBBAA, 3'b000, 3'b100, 24'hCCBBAA, 1'b0, 1'b1};
      vecs[3] = '{24'h5A00FF, 3'b001, 3'b001, 24'h5A00FF, PAR_EN, 1'b1};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_valid", m_valid, 0);
      chk("rst_data", m_data, 0);
      chk("rst_perr", m_parity_err, 0);
      chk("rst_ferr", m_frame_err, 0);
      chk("rst_ovf", overflow, 0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // Table-driven frames with m_ready held high
      for (int v = 0; v < 4; v++) begin
         vc_base = valid_cyc;
         send_frame(vecs[v].frame, vecs[v].bad_par, vecs[v].bad_stop);
         expect_frame($sformatf("vec%0d", v), vecs[v].exp_d, vecs[v].exp_pe, vecs[v].exp_fe);
         chk($sformatf("vec%0d_valid_cycles", v), valid_cyc - vc_base, 1);
      end

      // One-clock low glitch on idle line must not start a word
      rx = 1'b0;
      @(posedge clk);
      #1;
      rx = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      send_frame(24'h030201, '0, '0);
      expect_frame("glitch", 24'h030201, 1'b0, 1'b0);

      // Overflow: two frames with sink stalled, second one dropped
      ovf_base = ovf_cnt;
      m_ready = 1'b0;
      send_frame(24'h111111, '0, '0);
      send_frame(24'h222222, '0, '0);
      repeat (5) @(posedge clk);
      #1;
      chk("ovf_valid_held", m_valid, 1);
      chk("ovf_data_held", m_data, 24'h111111);
      chk("ovf_pulses", ovf_cnt - ovf_base, 1);
      m_ready = 1'b1;
      @(negedge clk);
      chk("ovf_valid_at_hs", m_valid, 1);
      @(negedge clk);
      chk("ovf_valid_after_hs", m_valid, 0);
      @(posedge clk);
      #1;
      expect_frame("ovf_out", 24'h111111, 1'b0, 1'b0);

      // Reset after two words discards the partial frame
      send_word(8'h11, 1'b0, 1'b0);
      send_word(8'h22, 1'b0, 1'b0);
      rstn = 1'b0;
      @(negedge clk);
      chk("midrst_valid", m_valid, 0);
      chk("midrst_data", m_data, 0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      send_frame(24'hCCBBAA, '0, '0);
      expect_frame("after_rst", 24'hCCBBAA, 1'b0, 1'b0);

      // Randomized frames against the word-level model
      ovf_base = ovf_cnt;
      for (int f = 0; f < 20; f++) begin
         rf = WO'($urandom);
         for (int w = 0; w < NW; w++) begin
            rbp[w] = ($urandom_range(0, 7) == 0);
            rbs[w] = ($urandom_range(0, 7) == 0);
         end
         send_frame(rf, rbp, rbs);
         expect_frame($sformatf("rnd%0d", f), rf, PAR_EN & (|rbp), |rbs);
      end
      chk("rnd_no_overflow", ovf_cnt - ovf_base, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
